// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM status encodings, BCD digit width and
// the default one-second divider.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10
  } sw_status_t;

  localparam int BCD_W            = 4;
  localparam int TICK_DIV_DEFAULT = 100_000_000;

  // Clear decode used by the integrating top: the counter resets while idle.
  function automatic logic clear_from_status(input sw_status_t status);
    return status == ST_IDLE;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit that wraps at MAX and reports a carry on its wrap.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = 4'd9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [BCD_W-1:0] digit,
  output logic             carry
);

  assign carry = inc && (digit == MAX);

  // ">= MAX" also scrubs any out-of-range value back to zero on increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          digit <= '0;
    else if (clear)      digit <= '0;
    else if (inc)        digit <= (digit >= MAX) ? '0 : digit + 1'b1;
  end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time base: divides clk into one-second events and advances a
// four-digit BCD MM:SS count with tick and wrap pulses.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic             sec_tick,
  output logic             rollover
);

  localparam int             NUM_DIGITS = 4;
  localparam int             DW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST   = DW'(TICK_DIV - 1);

  logic [DW-1:0]                       div_cnt;
  logic                                sec_evt;
  logic [NUM_DIGITS:0]                 inc_chain;
  logic [NUM_DIGITS-1:0][BCD_W-1:0]    digits;

  // Prescaler only moves while enabled, so a pause keeps the sub-second phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              div_cnt <= '0;
    else if (clear)          div_cnt <= '0;
    else if (enable)         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  assign sec_evt      = enable && !clear && (div_cnt == DIV_LAST);
  assign inc_chain[0] = sec_evt;

  // Digit order: sec_ones, sec_tens, min_ones, min_tens; only sec_tens wraps at 5.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit #(
      .MAX ((i == 1) ? 4'd5 : 4'd9)
    ) u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .inc   (inc_chain[i]),
      .digit (digits[i]),
      .carry (inc_chain[i+1])
    );
  end

  // Pulses line up with the cycle in which the new digits are visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_tick <= 1'b0;
      rollover <= 1'b0;
    end else if (clear) begin
      sec_tick <= 1'b0;
      rollover <= 1'b0;
    end else begin
      sec_tick <= sec_evt;
      rollover <= inc_chain[NUM_DIGITS];
    end
  end

  assign sec_ones = digits[0];
  assign sec_tens = digits[1];
  assign min_ones = digits[2];
  assign min_tens = digits[3];

endmodule
